ttt_game_ctrl: RTL and testbench

- Game-sequencing controller for the 3x3 tic-tac-toe display path.
- Accepts cell-select key events, validates each move, alternates players and writes the 18-bit board vector consumed by the dot-matrix display block.
- Scans the eight winning lines one per cycle after each move and flags win, draw or illegal move.
- Sits between the keypad decoder and the display driver; it is the sole owner and writer of `board`.

---
 rtl/ttt_game_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// ttt_game_ctrl: tic-tac-toe game sequencer between the keypad decoder and the
// dot-matrix display driver. Validates cell-select key events, writes the board,
// scans the eight winning lines one per cycle and reports win/draw/illegal move.
//
// Ports:
//   freq       in   system clock, rising edge
//   rst        in   synchronous active-low reset
//   key_valid  in   keypad strobe (level); an event is a 0->1 transition
//   key_code   in   1..9 cell (row-major), KEY_RESTART clears the game
//   board      out  cell i at bits [2i+1:2i]; 0 empty, 1 X, 2 O
//   turn       out  player to move next (1 or 2)
//   winner     out  0 none, 1 X, 2 O, 3 draw
//   game_over  out  high once the game has ended
//   move_err   out  one-cycle pulse on a rejected move
//   busy       out  high while a move is being checked, written or evaluated
module ttt_game_ctrl #(
  parameter logic [1:0] FIRST_PLAYER = 2'd1,
  parameter logic [3:0] KEY_RESTART  = 4'hF
) (
  input  logic        freq,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [17:0] board,
  output logic [1:0]  turn,
  output logic [1:0]  winner,
  output logic        game_over,
  output logic        move_err,
  output logic        busy
);

  localparam int unsigned BOARD_W = 18;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_EVAL,
    S_OVER
  } state_e;

  state_e              state_q, state_d;
  logic [BOARD_W-1:0]  board_q, board_d;
  logic [1:0]          turn_q, turn_d;
  logic [1:0]          winner_q, winner_d;
  logic                over_q, over_d;
  logic                err_q, err_d;
  logic                err_pend_q, err_pend_d;
  logic                busy_q, busy_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                key_hist_q;

  logic                key_evt_c;
  logic                restart_c;
  logic                cell_evt_c;
  logic                code_ok_c;
  logic [CODE_W-1:0]   cell_idx_c;
  logic [1:0]          cell_val_c;
  logic [11:0]         line_c;
  logic                line_win_c;

  // Cell indices {a,b,c} of winning line i, in scan order
  function automatic logic [11:0] line_cells(input logic [IDX_W-1:0] i);
    case (i)
      3'd0:    return {4'd0, 4'd1, 4'd2};
      3'd1:    return {4'd3, 4'd4, 4'd5};
      3'd2:    return {4'd6, 4'd7, 4'd8};
      3'd3:    return {4'd0, 4'd3, 4'd6};
      3'd4:    return {4'd1, 4'd4, 4'd7};
      3'd5:    return {4'd2, 4'd5, 4'd8};
      3'd6:    return {4'd0, 4'd4, 4'd8};
      default: return {4'd2, 4'd4, 4'd6};
    endcase
  endfunction

  // Rising-edge event detect; history is forced high in reset so a held key is ignored
  assign key_evt_c  = key_valid & ~key_hist_q;
  assign restart_c  = key_evt_c & (key_code == KEY_RESTART);
  assign cell_evt_c = key_evt_c & ~restart_c;

  // Latched code decode; out-of-range codes are steered to cell 0 to keep the select in range
  assign code_ok_c  = (code_q >= 4'd1) && (code_q <= 4'd9);
  assign cell_idx_c = code_ok_c ? CODE_W'(code_q - 4'd1) : '0;
  assign cell_val_c = board_q[{cell_idx_c, 1'b0} +: 2];

  // Current line under test; turn is never 0 so empty cells cannot match
  assign line_c     = line_cells(idx_q);
  assign line_win_c = (board_q[{line_c[11:8], 1'b0} +: 2] == turn_q) &&
                      (board_q[{line_c[7:4],  1'b0} +: 2] == turn_q) &&
                      (board_q[{line_c[3:0],  1'b0} +: 2] == turn_q);

  // Next-state and output logic
  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    winner_d   = winner_q;
    over_d     = over_q;
    err_d      = 1'b0;
    err_pend_d = 1'b0;
    code_d     = code_q;
    count_d    = count_q;
    idx_d      = idx_q;

    case (state_q)
      S_IDLE: begin
        if (cell_evt_c) begin
          code_d  = key_code;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (code_ok_c && (cell_val_c == 2'd0)) begin
          state_d = S_WRITE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        board_d[{cell_idx_c, 1'b0} +: 2] = turn_q;
        count_d = CNT_W'(count_q + 4'd1);
        idx_d   = '0;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (line_win_c) begin
          winner_d = turn_q;
          over_d   = 1'b1;
          state_d  = S_OVER;
        end else if (idx_q == 3'd7) begin
          if (count_q == 4'd9) begin
            winner_d = 2'd3;
            over_d   = 1'b1;
            state_d  = S_OVER;
          end else begin
            turn_d  = (turn_q == 2'd1) ? 2'd2 : 2'd1;
            state_d = S_IDLE;
          end
        end else begin
          idx_d = IDX_W'(idx_q + 3'd1);
        end
      end
      S_OVER: begin
        // Moves after the game ends are rejected one cycle later, like a failed CHECK
        err_d      = err_pend_q;
        err_pend_d = cell_evt_c;
      end
      default: state_d = S_IDLE;
    endcase

    // Restart wins over everything, including an EVAL in progress
    if (restart_c) begin
      state_d    = S_IDLE;
      board_d    = '0;
      turn_d     = FIRST_PLAYER;
      winner_d   = 2'd0;
      over_d     = 1'b0;
      err_d      = 1'b0;
      err_pend_d = 1'b0;
      count_d    = '0;
      idx_d      = '0;
    end

    busy_d = (state_d == S_CHECK) || (state_d == S_WRITE) || (state_d == S_EVAL);
  end

  // State and output registers
  always_ff @(posedge freq) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      board_q    <= '0;
      turn_q     <= FIRST_PLAYER;
      winner_q   <= 2'd0;
      over_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      code_q     <= '0;
      count_q    <= '0;
      idx_q      <= '0;
      key_hist_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      winner_q   <= winner_d;
      over_q     <= over_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      busy_q     <= busy_d;
      code_q     <= code_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      key_hist_q <= key_valid;
    end
  end

  assign board     = board_q;
  assign turn      = turn_q;
  assign winner    = winner_q;
  assign game_over = over_q;
  assign move_err  = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Scoreboard bench for ttt_game_ctrl: stimulus pushes the hand-computed outcome of
// each move, a negedge monitor pops and compares whenever the DUT finishes a move,
// pulses move_err or leaves the game-over state.
module tb_ttt_game_ctrl;

  typedef struct {
    logic [17:0] board;
    logic [1:0]  turn;
    logic [1:0]  winner;
    logic        go;
    logic        err;
    int          exp_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic [1:0]  turn;
  logic [1:0]  winner;
  logic        game_over;
  logic        move_err;
  logic        busy;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;

  ttt_game_ctrl #(.FIRST_PLAYER(2'd1), .KEY_RESTART(4'hF)) dut (
    .freq      (clk),
    .rst       (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .board     (board),
    .turn      (turn),
    .winner    (winner),
    .game_over (game_over),
    .move_err  (move_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic exp_t mk(input logic [17:0] b, input logic [1:0] t, input logic [1:0] w,
                              input logic g, input logic e);
    exp_t r;
    r.board = b; r.turn = t; r.winner = w; r.go = g; r.err = e; r.exp_edge = -1;
    return r;
  endfunction

  // Monitor: one response per completed move, move_err pulse or exit from game over
  logic prev_busy, prev_go;
  always @(negedge clk) begin : monitor
    exp_t e;
    logic trig;
    trig = (prev_busy === 1'b1 && busy === 1'b0) || (move_err === 1'b1) ||
           (prev_go === 1'b1 && game_over === 1'b0);
    if (trig) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected: response board=0x%05h turn=%0d winner=%0d go=%0b err=%0b with nothing expected (cycle %0d)",
                 board, turn, winner, game_over, move_err, cyc);
      end else begin
        e = sb.pop_front();
        chk("outputs", {8'd0, board, turn, winner, game_over, move_err},
            {8'd0, e.board, e.turn, e.winner, e.go, e.err});
        if (e.exp_edge >= 0) chk("latency", 32'(cyc), 32'(e.exp_edge));
      end
    end
    prev_busy = busy;
    prev_go   = game_over;
  end

  // Key event at the posedge this task ends on; optionally expect a response lat edges later
  task automatic press(input logic [3:0] code, input bit push, input exp_t e, input int lat);
    @(negedge clk); key_valid = 1'b0; key_code = code;
    @(negedge clk); key_valid = 1'b1;
    @(posedge clk); #1;
    if (push) begin
      e.exp_edge = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expected responses never seen within %0d cycles", sb.size(), max_cyc);
      sb.delete();
    end
  endtask

  task automatic mv(input logic [3:0] code, input logic [17:0] b, input logic [1:0] t,
                    input logic [1:0] w, input logic g, input logic e, input int lat);
    press(code, 1'b1, mk(b, t, w, g, e), lat);
    drain(30);
  endtask

  initial begin : stim
    exp_t r;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {7'd0, board, turn, winner, game_over, move_err, busy},
        {7'd0, 18'h0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0});
    @(negedge clk); rst_n = 1'b1;

    // X wins on line 0 (top row): X1 O4 X2 O5 X3
    mv(4'd1, 18'h00001, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd4, 18'h00081, 2'd1, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd2, 18'h00085, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd5, 18'h00285, 2'd1, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd3, 18'h00295, 2'd1, 2'd1, 1'b1, 1'b0, 3);
    // Move after game over is rejected, board unchanged
    mv(4'd6, 18'h00295, 2'd1, 2'd1, 1'b1, 1'b1, 1);
    // Restart out of game over
    mv(4'hF, 18'h00000, 2'd1, 2'd0, 1'b0, 1'b0, 0);

    // Occupied cell and illegal codes rejected
    mv(4'd1, 18'h00001, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd1, 18'h00001, 2'd2, 2'd0, 1'b0, 1'b1, 1);
    mv(4'd0, 18'h00001, 2'd2, 2'd0, 1'b0, 1'b1, 1);
    mv(4'hA, 18'h00001, 2'd2, 2'd0, 1'b0, 1'b1, 1);
    // Restart from idle produces no response; check outputs directly
    press(4'hF, 1'b0, mk(18'h0, 2'd0, 2'd0, 1'b0, 1'b0), 0);
    chk("restart_idle", {9'd0, board, turn, winner, game_over, busy},
        {9'd0, 18'h0, 2'd1, 2'd0, 1'b0, 1'b0});

    // Draw: 1,2,3,5,4,6,8,7,9 -> X,O,X,X,O,O,O,X,X
    mv(4'd1, 18'h00001, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd2, 18'h00009, 2'd1, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd3, 18'h00019, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd5, 18'h00219, 2'd1, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd4, 18'h00259, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd6, 18'h00A59, 2'd1, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd8, 18'h04A59, 2'd2, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd7, 18'h06A59, 2'd1, 2'd0, 1'b0, 1'b0, 10);
    mv(4'd9, 18'h16A59, 2'd1, 2'd3, 1'b1, 1'b0, 10);
    mv(4'hF, 18'h00000, 2'd1, 2'd0, 1'b0, 1'b0, 0);

    // Restart during EVAL aborts the move; its result must never appear
    press(4'd5, 1'b0, mk(18'h0, 2'd0, 2'd0, 1'b0, 1'b0), 0);
    repeat (2) @(negedge clk);
    press(4'hF, 1'b1, mk(18'h00000, 2'd1, 2'd0, 1'b0, 1'b0), 0);
    repeat (20) @(posedge clk);
    drain(5);

    // Key held high: a single move; a second event during EVAL is dropped
    press(4'd1, 1'b1, mk(18'h00001, 2'd2, 2'd0, 1'b0, 1'b0), 10);
    repeat (50) @(posedge clk);
    drain(5);
    press(4'd2, 1'b1, mk(18'h00009, 2'd1, 2'd0, 1'b0, 1'b0), 10);
    repeat (2) @(negedge clk);
    press(4'd3, 1'b0, mk(18'h0, 2'd0, 2'd0, 1'b0, 1'b0), 0);
    drain(30);
    repeat (5) @(posedge clk);

    // Reset during EVAL with key held across it
    press(4'd4, 1'b0, mk(18'h0, 2'd0, 2'd0, 1'b0, 1'b0), 0);
    r = mk(18'h00000, 2'd1, 2'd0, 1'b0, 1'b0);
    r.exp_edge = cyc + 4;
    sb.push_back(r);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    drain(5);
    #1;
    chk("after_reset", {7'd0, board, turn, winner, game_over, move_err, busy},
        {7'd0, 18'h0, 2'd1, 2'd0, 1'b0, 1'b0, 1'b0});
    mv(4'd5, 18'h00100, 2'd2, 2'd0, 1'b0, 1'b0, 10);

    repeat (5) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
